// File: rtl/uart_host_rx.sv
// uart_host_rx: UART receiver (8N1, LSB first) feeding a small byte FIFO
// that the host side drains with rd_en. Also reports framing errors and
// dropped bytes.
`timescale 1ns/1ps

module uart_host_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   count,
    output logic               busy,
    output logic               frame_err,
    output logic               overflow,
    input  logic               clr_err
);

    localparam int              DEPTH_N   = 2 ** FIFO_AW;
    localparam int              CW        = FIFO_AW + 1;
    localparam logic [CW-1:0]   DEPTH     = CW'(DEPTH_N);
    localparam logic [15:0]     HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]     FULL_LOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               sync_q;
    logic               rx_s;
    logic [15:0]        bit_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift_reg;
    logic               expire;
    logic               push;
    logic               stop_bad;
    logic               do_push;
    logic               do_pop;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [7:0]         mem [DEPTH_N];

    assign expire = (bit_cnt == 16'd0);

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= rx;
            rx_s   <= sync_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; the line is only watched for a falling edge in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!rx_s) next_state = START;
            START: if (expire) next_state = rx_s ? IDLE : DATA;
            DATA:  if (expire && (bit_idx == 3'd7)) next_state = STOP;
            STOP:  if (expire) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: busy flag and the stop-bit verdict strobes.
    always_comb begin
        busy     = (state != IDLE);
        push     = 1'b0;
        stop_bad = 1'b0;
        if ((state == STOP) && expire) begin
            push     = rx_s;
            stop_bad = !rx_s;
        end
    end

    // Bit-period counter, bit index and data shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) bit_cnt <= HALF_LOAD;
                end
                START: begin
                    if (expire) begin
                        bit_cnt <= FULL_LOAD;
                        bit_idx <= 3'd0;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (expire) begin
                        shift_reg[bit_idx] <= rx_s;
                        bit_cnt            <= FULL_LOAD;
                        bit_idx            <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (!expire) bit_cnt <= bit_cnt - 16'd1;
                end
                default: bit_cnt <= 16'd0;
            endcase
        end
    end

    // Registered one-cycle frame error pulse on a low stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
        end
    end

    // A push into a full FIFO is accepted only if a pop frees a slot this cycle.
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);

    // FIFO storage; contents are not reset since rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift_reg;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full && !do_pop) begin
            overflow <= 1'b1;
        end else if (clr_err) begin
            overflow <= 1'b0;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_host_rx.sv
// tb_uart_host_rx: directed test of the UART receiver and its FIFO, using a
// 4-entry FIFO so overflow and full-with-pop cases are reachable quickly.
`timescale 1ns/1ps

module tb_uart_host_rx;

    localparam int CPB = 16;
    localparam int AW  = 2;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          rx      = 1'b1;
    logic          rd_en   = 1'b0;
    logic          clr_err = 1'b0;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          busy;
    logic          frame_err;
    logic          overflow;

    int n_vec       = 0;
    int n_err       = 0;
    int fe_pulses   = 0;
    int busy_cycles = 0;
    int fe0;
    int b0;
    int bdiff;

    uart_host_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clr_err   (clr_err)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Count frame error pulses and busy cycles on the falling edge.
    always @(negedge clk) begin
        if (frame_err) fe_pulses++;
        if (busy) busy_cycles++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame starting at the current falling edge; ends with line idle.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pop_byte();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        check_output("rst_empty", 32'(empty), 32'd1);
        check_output("rst_full", 32'(full), 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_ferr", 32'(frame_err), 32'd0);
        check_output("rst_ovf", 32'(overflow), 32'd0);
        check_output("rst_rdata", 32'(rd_data), 32'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] two clean bytes");
        fe0 = fe_pulses;
        apply_stimulus(8'h55, 1'b1);
        check_output("b55_count", 32'(count), 32'd1);
        check_output("b55_rdata", 32'(rd_data), 32'h55);
        apply_stimulus(8'hA3, 1'b1);
        check_output("bA3_count", 32'(count), 32'd2);
        check_output("bA3_head", 32'(rd_data), 32'h55);
        pop_byte();
        check_output("pop1_rdata", 32'(rd_data), 32'hA3);
        check_output("pop1_count", 32'(count), 32'd1);
        pop_byte();
        check_output("pop2_empty", 32'(empty), 32'd1);
        check_output("clean_ovf", 32'(overflow), 32'd0);
        check_output("clean_ferr", 32'(fe_pulses - fe0), 32'd0);

        $display("[TB] start-bit glitch");
        fe0 = fe_pulses;
        b0  = busy_cycles;
        rx  = 1'b0;
        repeat (6) @(negedge clk);
        rx  = 1'b1;
        repeat (20) @(negedge clk);
        bdiff = busy_cycles - b0;
        check_output("glitch_busy_len", 32'((bdiff >= 1) && (bdiff <= 9)), 32'd1);
        check_output("glitch_count", 32'(count), 32'd0);
        check_output("glitch_ferr", 32'(fe_pulses - fe0), 32'd0);
        check_output("glitch_idle", 32'(busy), 32'd0);

        $display("[TB] framing error then recovery");
        fe0 = fe_pulses;
        apply_stimulus(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk);
        check_output("ferr_pulses", 32'(fe_pulses - fe0), 32'd1);
        check_output("ferr_count", 32'(count), 32'd0);
        apply_stimulus(8'h7E, 1'b1);
        check_output("b7E_count", 32'(count), 32'd1);
        check_output("b7E_rdata", 32'(rd_data), 32'h7E);
        check_output("b7E_ferr", 32'(fe_pulses - fe0), 32'd1);
        pop_byte();

        $display("[TB] pop while empty");
        pop_byte();
        check_output("upop_count", 32'(count), 32'd0);
        check_output("upop_empty", 32'(empty), 32'd1);

        $display("[TB] overflow");
        apply_stimulus(8'h01, 1'b1);
        check_output("ovf_head01", 32'(rd_data), 32'h01);
        apply_stimulus(8'h02, 1'b1);
        apply_stimulus(8'h03, 1'b1);
        check_output("ovf_c3_full", 32'(full), 32'd0);
        apply_stimulus(8'h04, 1'b1);
        check_output("ovf_c4_full", 32'(full), 32'd1);
        check_output("ovf_c4_count", 32'(count), 32'd4);
        check_output("ovf_c4_flag", 32'(overflow), 32'd0);
        apply_stimulus(8'h05, 1'b1);
        check_output("ovf_drop_count", 32'(count), 32'd4);
        check_output("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check_output($sformatf("ovf_pop%0d", i), 32'(rd_data), 32'(i));
            pop_byte();
        end
        check_output("ovf_drained", 32'(empty), 32'd1);
        check_output("ovf_sticky", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_output("ovf_cleared", 32'(overflow), 32'd0);

        $display("[TB] push and pop while full");
        apply_stimulus(8'h0A, 1'b1);
        apply_stimulus(8'h0B, 1'b1);
        apply_stimulus(8'h0C, 1'b1);
        apply_stimulus(8'h0D, 1'b1);
        check_output("pp_full", 32'(full), 32'd1);
        fork
            apply_stimulus(8'h0E, 1'b1);
            begin
                repeat (154) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        check_output("pp_count", 32'(count), 32'd4);
        check_output("pp_ovf", 32'(overflow), 32'd0);
        check_output("pp_head", 32'(rd_data), 32'h0B);
        pop_byte();
        check_output("pp_pop0C", 32'(rd_data), 32'h0C);
        pop_byte();
        check_output("pp_pop0D", 32'(rd_data), 32'h0D);
        pop_byte();
        check_output("pp_tail0E", 32'(rd_data), 32'h0E);
        check_output("pp_left", 32'(count), 32'd1);

        $display("[TB] reset during data bit 4");
        fe0 = fe_pulses;
        fork
            apply_stimulus(8'hFF, 1'b1);
            begin
                repeat (88) @(negedge clk);
                check_output("mid_busy", 32'(busy), 32'd1);
                rst_n = 1'b0;
                #1;
                check_output("mrst_busy", 32'(busy), 32'd0);
                check_output("mrst_count", 32'(count), 32'd0);
                check_output("mrst_empty", 32'(empty), 32'd1);
                check_output("mrst_full", 32'(full), 32'd0);
                check_output("mrst_rdata", 32'(rd_data), 32'h00);
                check_output("mrst_ovf", 32'(overflow), 32'd0);
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check_output("post_rst_count", 32'(count), 32'd0);
        apply_stimulus(8'h12, 1'b1);
        check_output("b12_count", 32'(count), 32'd1);
        check_output("b12_rdata", 32'(rd_data), 32'h12);
        check_output("b12_ferr", 32'(fe_pulses - fe0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
